// File: rtl/id_ex_pipe_reg_pkg.sv
// rtl/id_ex_pipe_reg_pkg.sv - shared widths and opcode encodings for the 16-bit pipeline
package id_ex_pipe_reg_pkg;

    localparam int ID_EX_DATA_W = 16;
    localparam int ID_EX_REG_W  = 4;
    localparam int ID_EX_OP_W   = 4;
    localparam int ID_EX_CNT_W  = 16;

    typedef enum logic [ID_EX_OP_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_ADDI = 4'h4,
        OP_BEQ  = 4'h6,
        OP_LW   = 4'h8,
        OP_SW   = 4'h9,
        OP_NOP  = 4'hF
    } opcode_e;

    // True when an opcode is the only memory-read instruction of the ISA.
    function automatic logic is_load(input logic [ID_EX_OP_W-1:0] op);
        return op == OP_LW;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// rtl/id_ex_pipe_reg_load_use_detect.sv - combinational load-use hazard compare
module load_use_detect
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int REG_W = ID_EX_REG_W
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    output logic             o_hazard
);

    logic w_ex_is_load;
    logic w_rs_match;
    logic w_rt_match;

    // R0 is hardwired zero, so a load targeting it can never feed a consumer.
    assign w_ex_is_load = i_ex_valid && i_ex_mem_read && (i_ex_rd != '0);
    assign w_rs_match   = i_id_uses_rs && (i_id_rs == i_ex_rd);
    assign w_rt_match   = i_id_uses_rt && (i_id_rt == i_ex_rd);
    assign o_hazard     = w_ex_is_load && (w_rs_match || w_rt_match);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use stall and bubble counter
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int REG_W  = ID_EX_REG_W,
    parameter int OP_W   = ID_EX_OP_W,
    parameter int CNT_W  = ID_EX_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  IF_ID_RegisterRs,
    input  logic [REG_W-1:0]  IF_ID_RegisterRt,
    input  logic              IF_ID_UsesRs,
    input  logic              IF_ID_UsesRt,
    input  logic [REG_W-1:0]  ID_RegisterRd,
    input  logic [OP_W-1:0]   ID_Opcode,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              hazard_stall,
    output logic [REG_W-1:0]  ID_EX_RegisterRs,
    output logic [REG_W-1:0]  ID_EX_RegisterRt,
    output logic [REG_W-1:0]  ID_EX_RegisterRd,
    output logic [OP_W-1:0]   ID_EX_Opcode,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic [DATA_W-1:0] ID_EX_ReadData1,
    output logic [DATA_W-1:0] ID_EX_ReadData2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic              ID_EX_Valid,
    output logic [CNT_W-1:0]  bubble_count
);

    logic [REG_W-1:0]  r_rs, r_rt, r_rd;
    logic [OP_W-1:0]   r_opcode;
    logic              r_reg_write, r_mem_read, r_mem_write, r_valid;
    logic [DATA_W-1:0] r_data1, r_data2, r_imm;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_hazard;
    logic              w_insert_bubble;
    logic              w_load_enable;
    logic              w_count_enable;
    logic [CNT_W-1:0]  w_bubble_count_next;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_mem_read),
        .i_ex_rd       (r_rd),
        .i_id_rs       (IF_ID_RegisterRs),
        .i_id_rt       (IF_ID_RegisterRt),
        .i_id_uses_rs  (IF_ID_UsesRs),
        .i_id_uses_rt  (IF_ID_UsesRt),
        .o_hazard      (w_hazard)
    );

    // Flush and load-use share one bubble so a coincident pair counts once.
    assign w_load_enable   = !mem_stall;
    assign w_insert_bubble = flush || w_hazard;
    assign w_count_enable  = w_load_enable && w_insert_bubble && (r_bubble_count != '1);

    always_comb begin
        w_bubble_count_next = r_bubble_count;
        if (w_count_enable) begin
            w_bubble_count_next = r_bubble_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_opcode    <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_imm       <= '0;
            r_valid     <= 1'b0;
        end else if (w_load_enable) begin
            if (w_insert_bubble) begin
                r_rs        <= '0;
                r_rt        <= '0;
                r_rd        <= '0;
                r_opcode    <= '0;
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_data1     <= '0;
                r_data2     <= '0;
                r_imm       <= '0;
                r_valid     <= 1'b0;
            end else begin
                r_rs        <= IF_ID_RegisterRs;
                r_rt        <= IF_ID_RegisterRt;
                r_rd        <= ID_RegisterRd;
                r_opcode    <= ID_Opcode;
                r_reg_write <= ID_RegWrite;
                r_mem_read  <= ID_MemRead;
                r_mem_write <= ID_MemWrite;
                r_data1     <= ID_ReadData1;
                r_data2     <= ID_ReadData2;
                r_imm       <= ID_Imm;
                r_valid     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_count <= '0;
        end else begin
            r_bubble_count <= w_bubble_count_next;
        end
    end

    assign hazard_stall     = w_hazard;
    assign ID_EX_RegisterRs = r_rs;
    assign ID_EX_RegisterRt = r_rt;
    assign ID_EX_RegisterRd = r_rd;
    assign ID_EX_Opcode     = r_opcode;
    assign ID_EX_RegWrite   = r_reg_write;
    assign ID_EX_MemRead    = r_mem_read;
    assign ID_EX_MemWrite   = r_mem_write;
    assign ID_EX_ReadData1  = r_data1;
    assign ID_EX_ReadData2  = r_data2;
    assign ID_EX_Imm        = r_imm;
    assign ID_EX_Valid      = r_valid;
    assign bubble_count     = r_bubble_count;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
    import id_ex_pipe_reg_pkg::*;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rs = 0, rt = 0, rd = 0, op = 0;
    logic        uses_rs = 0, uses_rt = 0, rw = 0, mr = 0, mw = 0;
    logic [15:0] d1 = 0, d2 = 0, imm = 0;
    logic        mem_stall = 0, flush = 0;

    logic        hz;
    logic [3:0]  o_rs, o_rt, o_rd, o_op;
    logic        o_rw, o_mr, o_mw, o_valid;
    logic [15:0] o_d1, o_d2, o_imm;
    logic [CW-1:0] o_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt),
        .IF_ID_UsesRs(uses_rs), .IF_ID_UsesRt(uses_rt),
        .ID_RegisterRd(rd), .ID_Opcode(op),
        .ID_RegWrite(rw), .ID_MemRead(mr), .ID_MemWrite(mw),
        .ID_ReadData1(d1), .ID_ReadData2(d2), .ID_Imm(imm),
        .mem_stall(mem_stall), .flush(flush),
        .hazard_stall(hz),
        .ID_EX_RegisterRs(o_rs), .ID_EX_RegisterRt(o_rt), .ID_EX_RegisterRd(o_rd),
        .ID_EX_Opcode(o_op), .ID_EX_RegWrite(o_rw), .ID_EX_MemRead(o_mr),
        .ID_EX_MemWrite(o_mw), .ID_EX_ReadData1(o_d1), .ID_EX_ReadData2(o_d2),
        .ID_EX_Imm(o_imm), .ID_EX_Valid(o_valid), .bubble_count(o_cnt)
    );

    // Model: the EX-stage instruction as a flat record plus an integer bubble tally.
    typedef struct {
        logic       valid;
        logic [3:0] rs, rt, rd, op;
        logic       rw, mr, mw;
        logic [15:0] d1, d2, imm;
    } ex_t;

    ex_t m_ex;
    int  m_cnt;

    function automatic ex_t empty_ex();
        ex_t e;
        e.valid = 0; e.rs = 0; e.rt = 0; e.rd = 0; e.op = 0;
        e.rw = 0; e.mr = 0; e.mw = 0; e.d1 = 0; e.d2 = 0; e.imm = 0;
        return e;
    endfunction

    function automatic logic model_hazard();
        if (!(m_ex.valid && m_ex.mr) || m_ex.rd == 0) return 1'b0;
        return (uses_rs && rs == m_ex.rd) || (uses_rt && rt == m_ex.rd);
    endfunction

    initial begin
        m_ex  = empty_ex();
        m_cnt = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex  = empty_ex();
            m_cnt = 0;
        end else if (!mem_stall) begin
            if (flush || model_hazard()) begin
                m_ex  = empty_ex();
                m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            end else begin
                m_ex.valid = 1; m_ex.rs = rs; m_ex.rt = rt; m_ex.rd = rd; m_ex.op = op;
                m_ex.rw = rw; m_ex.mr = mr; m_ex.mw = mw;
                m_ex.d1 = d1; m_ex.d2 = d2; m_ex.imm = imm;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("hazard_stall", 32'(hz), 32'(model_hazard()));
        check("valid", 32'(o_valid), 32'(m_ex.valid));
        check("rs", 32'(o_rs), 32'(m_ex.rs));
        check("rt", 32'(o_rt), 32'(m_ex.rt));
        check("rd", 32'(o_rd), 32'(m_ex.rd));
        check("opcode", 32'(o_op), 32'(m_ex.op));
        check("ctrl", {29'd0, o_rw, o_mr, o_mw}, {29'd0, m_ex.rw, m_ex.mr, m_ex.mw});
        check("data1", 32'(o_d1), 32'(m_ex.d1));
        check("data2", 32'(o_d2), 32'(m_ex.d2));
        check("imm", 32'(o_imm), 32'(m_ex.imm));
        check("bubble_count", 32'(o_cnt), 32'(m_cnt));
    end

    task automatic set_id(input logic [3:0] a_rs, input logic [3:0] a_rt, input logic a_urs,
                          input logic a_urt, input logic [3:0] a_rd, input logic [3:0] a_op,
                          input logic a_rw, input logic a_mr, input logic [15:0] a_d1);
        rs = a_rs; rt = a_rt; uses_rs = a_urs; uses_rt = a_urt; rd = a_rd; op = a_op;
        rw = a_rw; mr = a_mr; mw = 0; d1 = a_d1; d2 = a_d1 ^ 16'h00FF; imm = {12'd0, a_rd};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        // Reset with nonzero inputs present
        set_id(4'd9, 4'd10, 1, 1, 4'd11, OP_LW, 1, 1, 16'hBEEF);
        #12;
        check("reset_valid", 32'(o_valid), 0);
        check("reset_hazard", 32'(hz), 0);
        check("reset_cnt", 32'(o_cnt), 0);
        check("reset_rd", 32'(o_rd), 0);
        rst_n = 1;

        // Pass-through
        set_id(4'd3, 4'd4, 1, 1, 4'd5, OP_AND, 1, 0, 16'h1234);
        step();
        check("pt_rs", 32'(o_rs), 3);
        check("pt_rt", 32'(o_rt), 4);
        check("pt_rd", 32'(o_rd), 5);
        check("pt_op", 32'(o_op), 2);
        check("pt_d1", 32'(o_d1), 32'h1234);
        check("pt_valid", 32'(o_valid), 1);
        check("pt_hazard", 32'(hz), 0);

        // Load-use on Rt
        set_id(4'd1, 4'd2, 1, 1, 4'd6, OP_LW, 1, 1, 16'h0040);
        step();
        set_id(4'd2, 4'd6, 1, 1, 4'd9, OP_ADD, 1, 0, 16'h5555);
        #1;
        check("lu_hazard", 32'(hz), 1);
        step();
        check("lu_bubble_valid", 32'(o_valid), 0);
        check("lu_bubble_rw", 32'(o_rw), 0);
        check("lu_cnt", 32'(o_cnt), 1);
        check("lu_hazard_drop", 32'(hz), 0);
        step();
        check("lu_dep_valid", 32'(o_valid), 1);
        check("lu_dep_rd", 32'(o_rd), 9);

        // R0 load never stalls
        set_id(4'd1, 4'd2, 1, 1, 4'd0, OP_LW, 1, 1, 16'h0001);
        step();
        set_id(4'd0, 4'd3, 1, 1, 4'd8, OP_ADD, 1, 0, 16'h0002);
        #1;
        check("r0_hazard", 32'(hz), 0);
        step();
        // Unused operand never stalls
        set_id(4'd1, 4'd2, 1, 1, 4'd7, OP_LW, 1, 1, 16'h0003);
        step();
        set_id(4'd3, 4'd7, 1, 0, 4'd8, OP_ADDI, 1, 0, 16'h0004);
        #1;
        check("unused_hazard", 32'(hz), 0);

        // Flush coinciding with hazard
        uses_rt = 1;
        #1;
        check("fh_hazard", 32'(hz), 1);
        flush = 1;
        step();
        flush = 0;
        check("fh_cnt", 32'(o_cnt), 2);
        check("fh_valid", 32'(o_valid), 0);
        step();

        // mem_stall during a pending load-use
        set_id(4'd1, 4'd2, 1, 1, 4'd6, OP_LW, 1, 1, 16'h0050);
        step();
        set_id(4'd6, 4'd0, 1, 0, 4'd10, OP_SUB, 1, 0, 16'h0060);
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ms_hazard", 32'(hz), 1);
            check("ms_cnt", 32'(o_cnt), 2);
            check("ms_rd", 32'(o_rd), 6);
        end
        mem_stall = 0;
        step();
        check("ms_bubble_cnt", 32'(o_cnt), 3);
        check("ms_bubble_valid", 32'(o_valid), 0);
        step();
        check("ms_dep_rd", 32'(o_rd), 10);

        // Saturation of the bubble counter
        flush = 1;
        for (int i = 0; i < 14; i++) step();
        flush = 0;
        check("sat_cnt", 32'(o_cnt), CNT_MAX);
        step();

        // Reset while a load-use stall is pending
        set_id(4'd1, 4'd2, 1, 1, 4'd5, OP_LW, 1, 1, 16'h0070);
        step();
        set_id(4'd5, 4'd2, 1, 0, 4'd12, OP_OR, 1, 0, 16'h0080);
        #1;
        check("rst_pre_hazard", 32'(hz), 1);
        #2;
        rst_n = 0;
        #1;
        check("rst_mid_hazard", 32'(hz), 0);
        check("rst_mid_valid", 32'(o_valid), 0);
        check("rst_mid_rd", 32'(o_rd), 0);
        check("rst_mid_cnt", 32'(o_cnt), 0);
        #1;
        rst_n = 1;
        step();
        base = 0;
        check("post_rst_valid", 32'(o_valid), 1);
        check("post_rst_cnt", 32'(o_cnt), base);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
